sd_req_arbiter: RTL
===================

SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- TIMEOUT_CYCLES, 24'd16_000_000, maximum cycles one SD operation may stay outstanding.
- MAX_RETRY, 2'd1, re-issues of a failed operation before error is reported.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk input 1 system clock; single clock domain.
- reset input 1 synchronous, active-high reset.
- req0/req1 input 1 requester request level, held until ack.
- we0/we1 input 1 1=block write, 0=block read; sampled with addr at grant.
- addr0/addr1 input 32 SD block address.
- wdata0/wdata1 input 4096 write block data.
- ack0/ack1 output 1 one-cycle completion pulse.
- err0/err1 output 1 one-cycle pulse coincident with ack when the operation failed.
- rdata output 4096 last read block; valid from ack onward until the next read completes.
- sd_addr output 32, sd_re output 1, sd_we output 1, sd_wdata output 4096: SD controller command side.
- sd_rdata input 4096; read_ok, read_err, write_ok, write_err, init_ok, init_err input 1: SD controller status levels.
- busy output 1 high in every state except IDLE; fault output 1 high in FAULT.

Function
REQ-003 FSM states SHALL be WAIT_INIT, IDLE, ISSUE, BUSY, RELEASE, FAULT.
REQ-004 WAIT_INIT SHALL go to IDLE on init_ok=1 and to FAULT on init_err=1 (init_err wins if both).
REQ-005 IDLE SHALL grant round-robin: the requester not most recently granted wins when both request; pointer after reset favours requester 0.
REQ-006 On grant the block SHALL latch we, addr and wdata of the winner and enter ISSUE the next cycle; later changes on requester inputs are ignored.
REQ-007 ISSUE/BUSY SHALL hold sd_re (read) or sd_we (write) high, never both, with sd_addr/sd_wdata stable.
REQ-008 In BUSY the matching ok level SHALL complete the operation; the matching err level, or the timeout counter reaching TIMEOUT_CYCLES-1, SHALL count as a failure; ok and err simultaneously SHALL count as failure.
REQ-009 On failure with retry count < MAX_RETRY the block SHALL pass through RELEASE, increment the retry count and re-enter ISSUE with the same latched command.
REQ-010 On success, or failure with retries exhausted, the block SHALL pulse ack (and err on failure) to the granted requester for exactly one cycle, drop sd_re/sd_we and enter RELEASE.
REQ-011 RELEASE SHALL keep sd_re=sd_we=0 until all of read_ok, read_err, write_ok, write_err are 0, then enter IDLE (minimum one cycle).
REQ-012 rdata SHALL load sd_rdata in the cycle a read succeeds; writes and failed reads leave rdata unchanged.
REQ-013 The timeout counter SHALL clear on entry to ISSUE and saturate, never wrap.
REQ-014 FAULT SHALL be terminal until reset: every request is answered with ack+err one cycle after req is seen, one requester per cycle, round-robin.
REQ-015 A requester dropping req before ack SHALL not abort the in-flight operation; ack still pulses.

Reset
REQ-016 On reset: state=WAIT_INIT, sd_re=sd_we=0, sd_addr=0, sd_wdata=0, rdata=0, ack/err=0, busy=1, fault=0, counters=0, round-robin pointer=0.
REQ-017 Reset asserted mid-operation SHALL take effect on the next clk edge, dropping sd_re/sd_we that cycle.

Structure
REQ-018 The state encoding and TIMEOUT/RETRY defaults SHALL live in the shared SD definitions include file.
REQ-019 The round-robin grant SHALL be a sub-module sd_rr_grant2 (2 requests, last-winner pointer, one-hot grant).

Verification
REQ-020 Benches SHALL cover:
- init_ok after 100 cycles, req0 read addr 0x10, read_ok after 50 -> sd_re high 50 cycles, ack0 pulse, err0=0, rdata=sd_rdata.
- req0 and req1 together, both writes -> req0 served first, then req1; sd_we never overlaps two grants.
- read_err once then read_ok, MAX_RETRY=1 -> two ISSUE entries, ack0 with err0=0.
- no status for TIMEOUT_CYCLES=64 -> two attempts of 64 cycles, ack1 with err1=1, rdata unchanged.
- init_err=1 -> fault=1; req0 -> ack0 and err0 one cycle later; sd_re/sd_we stay 0.
- reset pulsed while BUSY -> next cycle sd_re=0, state WAIT_INIT, no ack.

Source files
------------

// File: rtl/sd_req_arbiter_pkg.sv
// Shared SD definitions: FSM state encoding, bus widths and the default
// timeout / retry settings used by the request arbiter.
package sd_req_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int BLK_W  = 4096;

    localparam logic [23:0] DEF_TIMEOUT_CYCLES = 24'd16_000_000;
    localparam logic [1:0]  DEF_MAX_RETRY      = 2'd1;

    typedef enum logic [2:0] {
        WAIT_INIT = 3'd0,
        IDLE      = 3'd1,
        ISSUE     = 3'd2,
        BUSY      = 3'd3,
        RELEASE   = 3'd4,
        FAULT     = 3'd5
    } state_t;

    // One-hot requester mask for requester index idx.
    function automatic logic [1:0] owner_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sd_req_arbiter_if.sv
// Requester, SD-controller and status signals of the arbiter, bundled.
// slave = arbiter view, master = environment (requesters + SD controller).
interface sd_req_arbiter_if;
    import sd_req_arbiter_pkg::*;

    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [BLK_W-1:0]  wdata0, wdata1;
    logic              ack0, ack1, err0, err1;
    logic [BLK_W-1:0]  rdata;

    logic [ADDR_W-1:0] sd_addr;
    logic              sd_re, sd_we;
    logic [BLK_W-1:0]  sd_wdata, sd_rdata;
    logic              read_ok, read_err, write_ok, write_err, init_ok, init_err;

    logic              busy, fault;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
               sd_rdata, read_ok, read_err, write_ok, write_err, init_ok, init_err,
        output ack0, ack1, err0, err1, rdata,
               sd_addr, sd_re, sd_we, sd_wdata, busy, fault
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
               sd_rdata, read_ok, read_err, write_ok, write_err, init_ok, init_err,
        input  ack0, ack1, err0, err1, rdata,
               sd_addr, sd_re, sd_we, sd_wdata, busy, fault
    );

endinterface

// File: rtl/sd_rr_grant2.sv
// Two-way round-robin grant. A tie goes to the requester that did not win
// last; the pointer moves whenever a grant is issued.
module sd_rr_grant2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic favour_q;  // index of the requester that wins a tie

    // One-hot grant from the current request vector and tie pointer.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        gnt = req;
        if (req == 2'b11) begin
            gnt = favour_q ? 2'b10 : 2'b01;
        end
    end

    // Tie pointer: after a grant, favour the requester that lost.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        if (reset) begin
            favour_q <= 1'b0;
        end else if (|gnt) begin
            favour_q <= gnt[0];
        end
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// Arbitrates two block requesters onto one SD controller: waits for card
// init, grants round-robin, retries failed operations, times out stalls.
module sd_req_arbiter
    import sd_req_arbiter_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [1:0]  MAX_RETRY      = DEF_MAX_RETRY
) (
    input logic             clk,
    input logic             reset,
    sd_req_arbiter_if.slave bus
);

    state_t            state_q, state_d;
    logic              cmd_we, cmd_owner;
    logic [ADDR_W-1:0] cmd_addr;
    logic [BLK_W-1:0]  cmd_wdata, rdata_q;
    logic [23:0]       cnt_q;
    logic [1:0]        retry_q, retry_d;
    logic              again_q, again_d;
    logic [1:0]        ack_q, ack_d, err_q, err_d;
    logic [1:0]        req_vec, gnt;
    logic              take, cnt_clr, rd_load;
    logic              op_ok, op_err, op_success, op_fail, status_any;

    sd_rr_grant2 u_grant (
        .clk   (clk),
        .reset (reset),
        .req   (req_vec),
        .gnt   (gnt)
    );

    assign op_ok      = cmd_we ? bus.write_ok  : bus.read_ok;
    assign op_err     = cmd_we ? bus.write_err : bus.read_err;
    assign op_success = op_ok && !op_err;
    assign op_fail    = !op_success && (op_err || (cnt_q >= TIMEOUT_CYCLES - 24'd1));
    assign status_any = bus.read_ok | bus.read_err | bus.write_ok | bus.write_err;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus per-cycle control strobes for the datapath.
    always_comb begin
        state_d = state_q;
        req_vec = 2'b00;
        take    = 1'b0;
        cnt_clr = 1'b0;
        rd_load = 1'b0;
        ack_d   = 2'b00;
        err_d   = 2'b00;
        retry_d = retry_q;
        again_d = again_q;
        case (state_q)
            WAIT_INIT: begin
                if (bus.init_err)     state_d = FAULT;
                else if (bus.init_ok) state_d = IDLE;
            end
            IDLE: begin
                req_vec = {bus.req1, bus.req0};
                if (|gnt) begin
                    take    = 1'b1;
                    cnt_clr = 1'b1;
                    retry_d = 2'd0;
                    again_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = BUSY;
            BUSY: begin
                if (op_success || op_fail) begin
                    state_d = RELEASE;
                    if (op_fail && (retry_q < MAX_RETRY)) begin
                        again_d = 1'b1;
                        retry_d = retry_q + 2'd1;
                    end else begin
                        again_d = 1'b0;
                        ack_d   = owner_onehot(cmd_owner);
                        err_d   = op_fail ? owner_onehot(cmd_owner) : 2'b00;
                        rd_load = op_success && !cmd_we;
                    end
                end
            end
            RELEASE: begin
                if (!status_any) begin
                    if (again_q) begin
                        cnt_clr = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FAULT: begin
                // Skip a requester whose ack is on the bus this cycle.
                req_vec = {bus.req1, bus.req0} & ~ack_q;
                ack_d   = gnt;
                err_d   = gnt;
            end
            default: state_d = WAIT_INIT;
        endcase
    end

    // Latched command, timeout/retry counters, read data and ack pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the wide data registers are reset too: their value is
            // visible on sd_wdata/rdata straight out of reset.
            cmd_we    <= 1'b0;
            cmd_owner <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            retry_q   <= '0;
            again_q   <= 1'b0;
            ack_q     <= '0;
            err_q     <= '0;
        end else begin
            if (take) begin
                cmd_owner <= gnt[1];
                cmd_we    <= gnt[1] ? bus.we1    : bus.we0;
                cmd_addr  <= gnt[1] ? bus.addr1  : bus.addr0;
                cmd_wdata <= gnt[1] ? bus.wdata1 : bus.wdata0;
            end
            if (rd_load) begin
                rdata_q <= bus.sd_rdata;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (((state_q == ISSUE) || (state_q == BUSY)) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 24'd1;
            end
            retry_q <= retry_d;
            again_q <= again_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.sd_re    = ((state_q == ISSUE) || (state_q == BUSY)) && !cmd_we;
    assign bus.sd_we    = ((state_q == ISSUE) || (state_q == BUSY)) && cmd_we;
    assign bus.sd_addr  = cmd_addr;
    assign bus.sd_wdata = cmd_wdata;
    assign bus.rdata    = rdata_q;
    assign bus.ack0     = ack_q[0];
    assign bus.ack1     = ack_q[1];
    assign bus.err0     = err_q[0];
    assign bus.err1     = err_q[1];
    assign bus.busy     = (state_q != IDLE);
    assign bus.fault    = (state_q == FAULT);

endmodule
